// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the mode-0 SPI master.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // Phase counter loads N-1, so $clog2 of the largest N is enough; never narrower than 1 bit.
  function automatic int spi_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-stream valid/ready handshake between frame-generation logic and spi_master.
interface spi_master_if;
  import spi_pkg::*;

  logic                  byte_valid_in;
  logic [SPI_BYTE_W-1:0] byte_data_in;
  logic                  byte_last_in;
  logic                  byte_ready_out;
  logic                  busy_out;

  modport master (
    output byte_valid_in, byte_data_in, byte_last_in,
    input  byte_ready_out, busy_out
  );

  modport slave (
    input  byte_valid_in, byte_data_in, byte_last_in,
    output byte_ready_out, busy_out
  );

endinterface

// File: rtl/spi_phase_cnt.sv
// Loadable down-counter timing every SPI phase; expire is high once the count reaches zero.
module spi_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one-byte hold buffer feeding a shift register, cs_n held low until a last-flagged byte.
// Defining SPI_MASTER_RX_EN adds a MISO receive path sampled on every SCLK rising edge.
module spi_master
  import spi_pkg::*;
#(
  parameter int DIV_HALF = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  spi_master_if.slave byte_if,
  output logic        spi_sclk_out,
  output logic        spi_mosi_out,
  output logic        spi_cs_n_out
`ifdef SPI_MASTER_RX_EN
  ,
  input  logic                  spi_miso_in,
  output logic [SPI_BYTE_W-1:0] rx_data_out,
  output logic                  rx_rdy_out
`endif
);

  localparam int CW = spi_cnt_w(DIV_HALF, CS_SETUP, CS_HOLD, CS_IDLE);
  localparam logic [CW-1:0] LD_DIV   = CW'(DIV_HALF - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] LD_IDLE  = CW'(CS_IDLE - 1);

  spi_state_t            state, state_nx;
  logic                  en, hold_full, hold_last, last_pending, ready, accept;
  logic [SPI_BYTE_W-1:0] hold_data;
  logic [SPI_BYTE_W-1:0] shreg, shreg_nx;
  logic [2:0]            bit_cnt, bit_cnt_nx;
  logic                  cur_last, cur_last_nx;
  logic                  sclk, sclk_nx, cs_n, cs_n_nx;
  logic                  take, cnt_load, expire;
  logic [CW-1:0]         cnt_val;

  spi_phase_cnt #(.W(CW)) u_phase (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (expire)
  );

  assign ready  = en & ~hold_full & ~last_pending;
  assign accept = byte_if.byte_valid_in & ready;

  always_comb begin
    state_nx    = state;
    sclk_nx     = sclk;
    cs_n_nx     = cs_n;
    shreg_nx    = shreg;
    bit_cnt_nx  = bit_cnt;
    cur_last_nx = cur_last;
    take        = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = LD_DIV;
    unique case (state)
      ST_IDLE: if (hold_full) begin
        take     = 1'b1;
        cs_n_nx  = 1'b0;
        cnt_load = 1'b1;
        cnt_val  = LD_SETUP;
        state_nx = ST_SETUP;
      end
      ST_SETUP, ST_LOW: if (expire) begin
        sclk_nx  = 1'b1;
        cnt_load = 1'b1;
        state_nx = ST_HIGH;
      end
      ST_HIGH: if (expire) begin
        sclk_nx  = 1'b0;
        cnt_load = 1'b1;
        if (bit_cnt != 3'd0) begin
          shreg_nx   = {shreg[SPI_BYTE_W-2:0], 1'b0};
          bit_cnt_nx = bit_cnt - 3'd1;
          state_nx   = ST_LOW;
        end else if (hold_full) begin
          take     = 1'b1;
          state_nx = ST_LOW;
        end else if (cur_last) begin
          cnt_val  = LD_HOLD;
          state_nx = ST_HOLD;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: if (hold_full) begin
        take     = 1'b1;
        cnt_load = 1'b1;
        state_nx = ST_LOW;
      end
      ST_HOLD: if (expire) begin
        cs_n_nx  = 1'b1;
        shreg_nx = '0;
        cnt_load = 1'b1;
        cnt_val  = LD_IDLE;
        state_nx = ST_GAP;
      end
      ST_GAP: if (expire) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Every load path (first byte, back-to-back, resume from WAIT) presents bit 7 on MOSI.
    if (take) begin
      shreg_nx    = hold_data;
      bit_cnt_nx  = 3'd7;
      cur_last_nx = hold_last;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      cur_last <= 1'b0;
    end else begin
      state    <= state_nx;
      sclk     <= sclk_nx;
      cs_n     <= cs_n_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_cnt_nx;
      cur_last <= cur_last_nx;
    end
  end

  // Accept can only happen while the buffer is empty, so it never races a reload.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      en           <= 1'b0;
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
      last_pending <= 1'b0;
    end else begin
      en <= 1'b1;
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= byte_if.byte_data_in;
        hold_last <= byte_if.byte_last_in;
      end else if (take) begin
        hold_full <= 1'b0;
      end
      if (accept && byte_if.byte_last_in) begin
        last_pending <= 1'b1;
      end else if (state_nx == ST_IDLE && state != ST_IDLE) begin
        last_pending <= 1'b0;
      end
    end
  end

  assign byte_if.byte_ready_out = ready;
  assign byte_if.busy_out       = (state != ST_IDLE) | hold_full;
  assign spi_sclk_out           = sclk;
  assign spi_cs_n_out           = cs_n;
  assign spi_mosi_out           = shreg[SPI_BYTE_W-1];

`ifdef SPI_MASTER_RX_EN
  logic [SPI_BYTE_W-1:0] rx_sh;
  logic                  rise;

  assign rise = (state_nx == ST_HIGH) && (state != ST_HIGH);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_sh       <= '0;
      rx_data_out <= '0;
      rx_rdy_out  <= 1'b0;
    end else begin
      rx_rdy_out <= 1'b0;
      if (rise) begin
        rx_sh <= {rx_sh[SPI_BYTE_W-2:0], spi_miso_in};
        if (bit_cnt == 3'd0) begin
          rx_data_out <= {rx_sh[SPI_BYTE_W-2:0], spi_miso_in};
          rx_rdy_out  <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master; a bus monitor rebuilds frames and bytes from the SPI pins.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int DH = 2, CSS = 2, CSH = 2, CSI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, mosi, cs_n;
  int   total = 0, bad = 0;
  int   cyc = 0;

  spi_master_if bif();

`ifdef SPI_MASTER_RX_EN
  logic [7:0] rx_data;
  logic       rx_rdy;
`endif

  spi_master #(.DIV_HALF(DH), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .byte_if      (bif.slave),
    .spi_sclk_out (sclk),
    .spi_mosi_out (mosi),
    .spi_cs_n_out (cs_n)
`ifdef SPI_MASTER_RX_EN
    ,
    .spi_miso_in  (mosi),
    .rx_data_out  (rx_data),
    .rx_rdy_out   (rx_rdy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records rising-edge times, MOSI bits, cs_n windows and protocol violations.
  int   rise_t[$];
  bit   bits[$];
  int   fall_t[$];
  int   low_len[$];
  int   rx_q[$];
  int   exp_q[$];
  int   frames = 0;
  int   viol = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sclk && !p_sclk) begin
        rise_t.push_back(cyc);
        bits.push_back(mosi);
      end
      if (!cs_n && p_cs) fall_t.push_back(cyc);
      if (cs_n && !p_cs) begin
        frames++;
        low_len.push_back(fall_t.size() > 0 ? cyc - fall_t[fall_t.size()-1] : -1);
      end
      if (!cs_n && !p_cs && sclk && (mosi !== p_mosi)) viol++;
      if (cs_n && sclk) viol++;
`ifdef SPI_MASTER_RX_EN
      if (rx_rdy) rx_q.push_back(int'(rx_data));
`endif
    end
    p_sclk = sclk;
    p_cs   = cs_n;
    p_mosi = mosi;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk);
    rise_t.delete(); bits.delete(); fall_t.delete(); low_len.delete(); rx_q.delete();
    frames = 0;
    viol = 0;
    @(negedge clk);
  endtask

  // Offer one byte from a negedge; t is the index of the accepting clock edge.
  task automatic send(input logic [7:0] d, input bit last, output int t);
    int n = 0;
    bif.byte_valid_in = 1'b1;
    bif.byte_data_in  = d;
    bif.byte_last_in  = last;
    while (!bif.byte_ready_out && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_in_time", int'(n < 500), 1);
    t = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    bif.byte_valid_in = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    int n = 0;
    while (!bif.byte_ready_out && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return_in_time", int'(n < 2000), 1);
    c = cyc;
  endtask

  task automatic wait_rises(input int k);
    int n = 0;
    while (rise_t.size() < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rises_in_time", int'(n < 2000), 1);
  endtask

  function automatic int get_byte(input int idx);
    int v = 0;
    for (int i = 0; i < 8; i++) v = (v << 1) | int'(bits[idx*8+i]);
    return v;
  endfunction

  function automatic int spacing_bad(input int lo, input int hi);
    int n = 0;
    for (int i = lo + 1; i < hi; i++)
      if (i < rise_t.size() && rise_t[i] - rise_t[i-1] != 2*DH) n++;
    return n;
  endfunction

  // Expected frame: exactly one cs_n window carrying exp_q MSB first, with the given low length.
  task automatic check_frame(input string tag, input int exp_len);
    chk({tag, "_frames"}, frames, 1);
    chk({tag, "_nbits"}, bits.size(), 8*exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk({tag, "_byte"}, (bits.size() >= 8*k+8) ? get_byte(k) : -1, exp_q[k]);
    chk({tag, "_cs_low"}, low_len.size() > 0 ? low_len[0] : -1, exp_len);
    chk({tag, "_viol"}, viol, 0);
  endtask

  initial begin
    int t0, t1, c, n, wbad;
    logic [7:0] d;
    bif.byte_valid_in = 1'b0;
    bif.byte_data_in  = '0;
    bif.byte_last_in  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_ready", int'(bif.byte_ready_out), 0);
    chk("rst_busy", int'(bif.busy_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(bif.byte_ready_out), 1);

    // Single byte 0xA5, last
    clr();
    send(8'hA5, 1'b1, t0);
    wait_ready(c);
    chk("a5_ready_latency", c - t0, 37);
    exp_q = '{8'hA5};
    check_frame("a5", CSS + 15*DH + CSH);
    chk("a5_cs_fall", fall_t.size() > 0 ? fall_t[0] - t0 : -1, 1);
    chk("a5_setup", (fall_t.size() > 0 && rise_t.size() > 0) ? rise_t[0] - fall_t[0] : -1, CSS);
    chk("a5_spacing", spacing_bad(0, 8), 0);

    // Three bytes streamed back to back
    clr();
    send(8'h01, 1'b0, t0);
    send(8'h80, 1'b0, t0);
    send(8'hFF, 1'b1, t0);
    wait_ready(c);
    exp_q = '{8'h01, 8'h80, 8'hFF};
    check_frame("stream3", CSS + 47*DH + CSH);
    chk("stream3_spacing", spacing_bad(0, 24), 0);

    // Random frames of 1..4 bytes
    for (int f = 0; f < 4; f++) begin
      clr();
      n = $urandom_range(1, 4);
      exp_q.delete();
      for (int b = 0; b < n; b++) begin
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(int'(d));
        send(d, b == n - 1, t0);
      end
      wait_ready(c);
      check_frame("rand", CSS + (16*n - 1)*DH + CSH);
      chk("rand_spacing", spacing_bad(0, 8*n), 0);
    end

    // Second byte offered late: link parks in WAIT with cs_n low, sclk low
    clr();
    send(8'h96, 1'b0, t0);
    wbad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cyc - t0 >= 34 && (sclk || cs_n || !bif.busy_out)) wbad++;
    end
    chk("wait_parked", wbad, 0);
    send(8'h69, 1'b1, t1);
    wait_rises(9);
    chk("wait_resume", rise_t.size() > 8 ? rise_t[8] - t1 : -1, 1 + DH);
    wait_ready(c);
    exp_q = '{8'h96, 8'h69};
    check_frame("late", t1 - t0 + 16*DH + CSH);
    chk("late_spacing_a", spacing_bad(0, 8), 0);
    chk("late_spacing_b", spacing_bad(8, 16), 0);

    // valid held high through HOLD and GAP is not latched
    clr();
    send(8'h3E, 1'b1, t0);
    bif.byte_valid_in = 1'b1;
    bif.byte_data_in  = 8'h77;
    bif.byte_last_in  = 1'b1;
    n = 0;
    while (!bif.byte_ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    bif.byte_valid_in = 1'b0;
    chk("hg_ready_latency", cyc - t0, 37);
    wbad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.busy_out || !cs_n) wbad++;
    end
    chk("hg_no_extra", wbad, 0);
    exp_q = '{8'h3E};
    check_frame("hg", CSS + 15*DH + CSH);

    // Reset after the third rising edge
    clr();
    send(8'hE7, 1'b1, t0);
    wait_rises(3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", int'(cs_n), 1);
    chk("mid_rst_sclk", int'(sclk), 0);
    chk("mid_rst_mosi", int'(mosi), 0);
    chk("mid_rst_ready", int'(bif.byte_ready_out), 0);
    chk("mid_rst_busy", int'(bif.busy_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    send(8'h5A, 1'b1, t0);
    wait_ready(c);
    exp_q = '{8'h5A};
    check_frame("post_rst", CSS + 15*DH + CSH);

`ifdef SPI_MASTER_RX_EN
    clr();
    send(8'h3C, 1'b1, t0);
    wait_ready(c);
    chk("rx_pulses", rx_q.size(), 1);
    chk("rx_data", rx_q.size() > 0 ? rx_q[0] : -1, 8'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
